// File: rtl/stq_commit_drain_ctrl_pkg.sv
// rtl/stq_commit_drain_ctrl_pkg.sv - shared LSU constants and types for the store drain controller
// Purpose: STQ geometry, commit width, in-flight write limit, index/count types and drain FSM states.
// Ports: none (package).
package stq_commit_drain_ctrl_pkg;

   localparam int SIZE_LSQ        = 32;
   localparam int SIZE_LSQ_LOG    = 5;
   localparam int COMMIT_WIDTH    = 4;
   localparam int MAX_OUTSTANDING = 2;

   typedef logic [SIZE_LSQ_LOG-1:0] stq_idx_t;
   typedef logic [SIZE_LSQ_LOG:0]   stq_cnt_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      BLOCKED = 2'd2
   } drain_state_t;

endpackage

// File: rtl/stq_commit_drain_ctrl_if.sv
// rtl/stq_commit_drain_ctrl_if.sv - D-cache store write port between drain controller and cache
// Purpose: groups the req/gnt/done handshake and the requested STQ index.
// Signals: dcWrReq_o (request), dcWrIndex_o (STQ index), dcWrGnt_i (accept), dcWrDone_i (oldest write done).
// Modports: master = drain controller, slave = D-cache.
interface stq_commit_drain_ctrl_if;
   import stq_commit_drain_ctrl_pkg::*;

   logic     dcWrReq_o;
   stq_idx_t dcWrIndex_o;
   logic     dcWrGnt_i;
   logic     dcWrDone_i;

   modport master (
      output dcWrReq_o,
      output dcWrIndex_o,
      input  dcWrGnt_i,
      input  dcWrDone_i
   );

   modport slave (
      input  dcWrReq_o,
      input  dcWrIndex_o,
      output dcWrGnt_i,
      output dcWrDone_i
   );

endinterface

// File: rtl/stq_commit_drain_ctrl_ptr_counter.sv
// rtl/stq_commit_drain_ctrl_ptr_counter.sv - wrap-around STQ pointer with increment enable
// Purpose: holds one STQ pointer; advances by one per enabled cycle, wrapping modulo SIZE_LSQ.
// Ports: clk, rst_n (async active-low), inc_i (advance), ptr_o (current pointer).
module stq_ptr_counter
   import stq_commit_drain_ctrl_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     inc_i,
   output stq_idx_t ptr_o
);

   stq_idx_t ptr_q;
   stq_idx_t ptr_d;

   // SIZE_LSQ is a power of two, so natural overflow of the index width is the wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) begin
         ptr_d = ptr_q + stq_idx_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/stq_commit_drain_ctrl.sv
// rtl/stq_commit_drain_ctrl.sv - drains committed stores from the STQ into the D-cache write port
// Purpose: counts committed stores, issues one in-order write per cycle over req/gnt, frees STQ
//          entries in order on completion, bounds in-flight writes and answers fence drain requests.
// Ports: clk, reset_n (async active-low), commitStCount_i (stores committed this cycle),
//        dc_if (D-cache write port, master side), stqFree_o / stqHeadPtr_o (in-order free),
//        pendingCnt_o (committed, not issued), drainReq_i / drainDone_o (fence), overflowErr_o (sticky).
module stq_commit_drain_ctrl
   import stq_commit_drain_ctrl_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [2:0]                      commitStCount_i,
   stq_commit_drain_ctrl_if.master         dc_if,
   output logic                            stqFree_o,
   output stq_idx_t                        stqHeadPtr_o,
   output stq_cnt_t                        pendingCnt_o,
   input  logic                            drainReq_i,
   output logic                            drainDone_o,
   output logic                            overflowErr_o
);

   drain_state_t state_q, state_d;
   stq_cnt_t     pending_q, pending_d;
   logic [1:0]   outst_q, outst_d;
   logic         err_q, err_d;
   logic         drain_done_q, drain_done_d;

   logic         dc_req;
   stq_idx_t     issue_ptr;
   stq_idx_t     head_ptr;
   logic         fire;
   logic         done_ok;
   logic         done_bad;
   logic         cnt_bad;
   logic [2:0]   commit_cnt;
   logic [6:0]   total;
   logic [6:0]   pend_raw;
   logic [6:0]   pend_lim;

   // Datapath: handshake events, counters, error detection.
   always_comb begin
      cnt_bad    = commitStCount_i > 3'(COMMIT_WIDTH);
      commit_cnt = cnt_bad ? 3'(COMMIT_WIDTH) : commitStCount_i;
      fire       = dc_req & dc_if.dcWrGnt_i;
      // A completion with nothing in flight has no entry to free; it is flagged, not counted.
      done_ok    = dc_if.dcWrDone_i & (outst_q != 2'd0);
      done_bad   = dc_if.dcWrDone_i & (outst_q == 2'd0);
      outst_d    = outst_q + {1'b0, fire} - {1'b0, done_ok};
      total      = 7'(pending_q) + 7'(outst_q) + 7'(commit_cnt);
      pend_raw   = 7'(pending_q) + 7'(commit_cnt) - 7'(fire);
      // Clamp so committed-but-unfreed entries never exceed the STQ.
      pend_lim   = 7'(SIZE_LSQ) - 7'(outst_d);
      pending_d  = (pend_raw > pend_lim) ? pend_lim[SIZE_LSQ_LOG:0] : pend_raw[SIZE_LSQ_LOG:0];
      err_d      = err_q | done_bad | cnt_bad | (total > 7'(SIZE_LSQ));
      drain_done_d = drainReq_i & (pending_q == '0) & (outst_q == 2'd0) & (commitStCount_i == 3'd0);
   end

   // FSM: the request output decodes the registered state; every state uses the same next-state rule.
   always_comb begin
      dc_req  = 1'b0;
      state_d = IDLE;
      case (state_q)
         ISSUE:   dc_req = 1'b1;
         BLOCKED: dc_req = 1'b0;
         default: dc_req = 1'b0;
      endcase
      if (pending_d != '0) begin
         state_d = (outst_d < 2'(MAX_OUTSTANDING)) ? ISSUE : BLOCKED;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         outst_q      <= 2'd0;
         err_q        <= 1'b0;
         drain_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         outst_q      <= outst_d;
         err_q        <= err_d;
         drain_done_q <= drain_done_d;
      end
   end

   stq_ptr_counter u_issue_ptr (
      .clk   (clk),
      .rst_n (reset_n),
      .inc_i (fire),
      .ptr_o (issue_ptr)
   );

   stq_ptr_counter u_head_ptr (
      .clk   (clk),
      .rst_n (reset_n),
      .inc_i (done_ok),
      .ptr_o (head_ptr)
   );

   // Index only advances on fire, so it stays stable while a request waits for grant.
   assign dc_if.dcWrReq_o   = dc_req;
   assign dc_if.dcWrIndex_o = issue_ptr;
   assign stqFree_o         = done_ok;
   assign stqHeadPtr_o      = head_ptr;
   assign pendingCnt_o      = pending_q;
   // Drops in the same cycle the fence request is withdrawn.
   assign drainDone_o       = drain_done_q & drainReq_i;
   assign overflowErr_o     = err_q;

endmodule

// File: tb/tb_stq_commit_drain_ctrl.sv
// tb/tb_stq_commit_drain_ctrl.sv - self-checking bench for the STQ commit drain controller
module tb_stq_commit_drain_ctrl;
   import stq_commit_drain_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] commitStCount_i;
   logic       stqFree_o;
   stq_idx_t   stqHeadPtr_o;
   stq_cnt_t   pendingCnt_o;
   logic       drainReq_i;
   logic       drainDone_o;
   logic       overflowErr_o;

   stq_commit_drain_ctrl_if dc_if ();

   stq_commit_drain_ctrl dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .commitStCount_i (commitStCount_i),
      .dc_if           (dc_if),
      .stqFree_o       (stqFree_o),
      .stqHeadPtr_o    (stqHeadPtr_o),
      .pendingCnt_o    (pendingCnt_o),
      .drainReq_i      (drainReq_i),
      .drainDone_o     (drainDone_o),
      .overflowErr_o   (overflowErr_o)
   );

   always #5 clk = ~clk;

   int       n_assert = 0;
   int       n_fail   = 0;
   int       cyc      = 0;
   int       next_commit_idx = 0;
   stq_idx_t exp_idx_q[$];
   stq_idx_t exp_free_q[$];
   int       done_at_q[$];
   bit       gnt_drv   = 1'b1;
   bit       auto_done = 1'b1;
   bit       man_done  = 1'b0;

   logic     s_req, s_fire, s_free, s_done, s_drain, s_err;
   stq_idx_t s_idx, s_head;
   stq_cnt_t s_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample 1ns later, score fires and frees.
   task automatic tick(input int cnt);
      stq_idx_t e;
      @(negedge clk);
      commitStCount_i  = 3'(cnt);
      dc_if.dcWrGnt_i  = gnt_drv;
      s_done           = man_done;
      if (auto_done && done_at_q.size() > 0 && done_at_q[0] == cyc) begin
         s_done = 1'b1;
         void'(done_at_q.pop_front());
      end
      dc_if.dcWrDone_i = s_done;
      for (int i = 0; i < cnt && i < COMMIT_WIDTH; i++) begin
         exp_idx_q.push_back(stq_idx_t'(next_commit_idx));
         next_commit_idx = (next_commit_idx + 1) % SIZE_LSQ;
      end
      #1;
      s_req   = dc_if.dcWrReq_o;
      s_idx   = dc_if.dcWrIndex_o;
      s_free  = stqFree_o;
      s_head  = stqHeadPtr_o;
      s_pend  = pendingCnt_o;
      s_drain = drainDone_o;
      s_err   = overflowErr_o;
      s_fire  = s_req & gnt_drv;
      if (s_fire) begin
         if (exp_idx_q.size() == 0) begin
            chk("fire_unexpected", 32'(s_fire), 32'd0);
         end else begin
            e = exp_idx_q.pop_front();
            chk("issue_idx", 32'(s_idx), 32'(e));
            exp_free_q.push_back(e);
         end
         done_at_q.push_back(cyc + 2);
      end
      if (auto_done) chk("free_pulse", 32'(s_free), 32'(s_done));
      if (s_free) begin
         if (exp_free_q.size() == 0) begin
            chk("free_unexpected", 32'(s_free), 32'd0);
         end else begin
            e = exp_free_q.pop_front();
            chk("free_head", 32'(s_head), 32'(e));
         end
      end
      cyc++;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 300; k++) begin
         tick(0);
         if (exp_idx_q.size() == 0 && exp_free_q.size() == 0) break;
      end
      if (k == 300) chk("idle_timeout", 32'(exp_free_q.size() + exp_idx_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n          = 1'b0;
      commitStCount_i  = 3'd0;
      dc_if.dcWrGnt_i  = 1'b0;
      dc_if.dcWrDone_i = 1'b0;
      drainReq_i       = 1'b0;
      #1;
      chk("rst_req",   32'(dc_if.dcWrReq_o), 32'd0);
      chk("rst_free",  32'(stqFree_o), 32'd0);
      chk("rst_drain", 32'(drainDone_o), 32'd0);
      chk("rst_err",   32'(overflowErr_o), 32'd0);
      chk("rst_pend",  32'(pendingCnt_o), 32'd0);
      exp_idx_q.delete();
      exp_free_q.delete();
      done_at_q.delete();
      next_commit_idx = 0;
      gnt_drv   = 1'b1;
      auto_done = 1'b1;
      man_done  = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      stq_idx_t   stall_idx;
      bit [5:0]   burst_pat = 6'b011011;

      reset_n          = 1'b0;
      commitStCount_i  = 3'd0;
      drainReq_i       = 1'b0;
      dc_if.dcWrGnt_i  = 1'b0;
      dc_if.dcWrDone_i = 1'b0;
      do_reset();
      tick(0);
      chk("init_head", 32'(s_head), 32'd0);
      chk("init_idx",  32'(s_idx), 32'd0);
      chk("init_req",  32'(s_req), 32'd0);

      // Single store: commit at t0, request at t1, done at t3 frees entry 0.
      tick(1);
      chk("single_t0_req", 32'(s_req), 32'd0);
      tick(0);
      chk("single_t1_req", 32'(s_req), 32'd1);
      chk("single_t1_idx", 32'(s_idx), 32'd0);
      tick(0);
      chk("single_t2_free", 32'(s_free), 32'd0);
      tick(0);
      chk("single_t3_free", 32'(s_free), 32'd1);
      tick(0);
      chk("single_t4_head", 32'(s_head), 32'd1);

      // Burst of 4 with done two cycles after each grant: issue, issue, blocked, issue, issue, idle.
      tick(4);
      for (int k = 0; k < 6; k++) begin
         tick(0);
         chk("burst_req_pattern", 32'(s_req), 32'(burst_pat[k]));
      end
      wait_idle();

      // Stall: grant withheld for 5 cycles while more stores commit.
      gnt_drv = 1'b0;
      tick(3);
      stall_idx = exp_idx_q[0];
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk("stall_req",  32'(s_req), 32'd1);
         chk("stall_idx",  32'(s_idx), 32'(stall_idx));
         chk("stall_pend", 32'(s_pend), 32'(k + 2));
      end
      gnt_drv = 1'b1;
      wait_idle();
      tick(0);
      chk("stall_pend_empty", 32'(s_pend), 32'd0);

      // Wrap: advance to index 30, then 4 stores must issue and free as 30,31,0,1.
      while (next_commit_idx != 30) begin
         tick((30 - next_commit_idx > 4) ? 4 : 30 - next_commit_idx);
      end
      wait_idle();
      tick(0);
      chk("prewrap_idx",  32'(s_idx), 32'd30);
      chk("prewrap_head", 32'(s_head), 32'd30);
      tick(4);
      wait_idle();
      tick(0);
      chk("wrap_head", 32'(s_head), 32'd2);
      chk("wrap_idx",  32'(s_idx), 32'd2);

      // Fence: drain done only after everything committed is written and freed.
      gnt_drv = 1'b0;
      tick(3);
      drainReq_i = 1'b1;
      tick(0);
      chk("fence_early", 32'(s_drain), 32'd0);
      gnt_drv = 1'b1;
      wait_idle();
      chk("fence_at_last_free", 32'(s_drain), 32'd0);
      tick(0);
      chk("fence_last_free_p1", 32'(s_drain), 32'd0);
      tick(0);
      chk("fence_done", 32'(s_drain), 32'd1);
      drainReq_i = 1'b0;
      tick(0);
      chk("fence_release", 32'(s_drain), 32'd0);

      // Completion with nothing in flight: ignored, sticky error.
      auto_done = 1'b0;
      man_done  = 1'b1;
      tick(0);
      chk("stray_done_free", 32'(s_free), 32'd0);
      chk("stray_done_err_pre", 32'(s_err), 32'd0);
      man_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(0);
         chk("stray_done_err_sticky", 32'(s_err), 32'd1);
      end
      do_reset();

      // Capacity: 32 committed is legal, the 33rd sets the error and pending saturates.
      gnt_drv = 1'b0;
      repeat (8) tick(4);
      tick(0);
      chk("cap32_pend", 32'(s_pend), 32'd32);
      chk("cap32_err",  32'(s_err), 32'd0);
      tick(1);
      tick(0);
      chk("cap33_err",  32'(s_err), 32'd1);
      chk("cap33_pend", 32'(s_pend), 32'd32);
      tick(0);
      chk("cap33_err_sticky", 32'(s_err), 32'd1);
      do_reset();

      // Commit count above width is clamped and flagged.
      gnt_drv = 1'b0;
      tick(5);
      tick(0);
      chk("wide_commit_err",  32'(s_err), 32'd1);
      chk("wide_commit_pend", 32'(s_pend), 32'd4);
      do_reset();

      // Reset mid-burst with 5 pending.
      gnt_drv = 1'b0;
      tick(4);
      tick(1);
      tick(0);
      chk("midrst_pend_before", 32'(s_pend), 32'd5);
      chk("midrst_req_before",  32'(s_req), 32'd1);
      do_reset();
      tick(0);
      chk("midrst_head", 32'(s_head), 32'd0);
      chk("midrst_idx",  32'(s_idx), 32'd0);
      chk("midrst_pend", 32'(s_pend), 32'd0);
      chk("midrst_req",  32'(s_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
